// File: rtl/vga_pkg.sv
// Shared constants, grid helper and FSM encoding for the ship position path.
package vga_pkg;

  localparam int GRID_MIN    = 1;
  localparam int GRID_MAX    = 8;
  localparam int MAX_CELLS   = 4;
  localparam int CELL_STRIDE = 8;
  localparam int X_MSB0      = 6;
  localparam int Y_MSB0      = 10;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_BLANK,
    COMMIT,
    ACK
  } updState_t;

  function automatic logic inGrid(input logic [3:0] v);
    return (v >= 4'(GRID_MIN)) && (v <= 4'(GRID_MAX));
  endfunction

endpackage

// File: rtl/vga_cell_check.sv
// Combinational validity check of a ship's cell list: count in 1..MAX_CELLS and
// every occupied cell inside the grid. Shared with the placement checker.
module vga_cell_check
  import vga_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  ncells,
  output logic        ok
);

  // Cells at or beyond ncells are don't-care and never reject the update.
  always_comb begin
    ok = (ncells != 3'd0) && (ncells <= 3'(MAX_CELLS));
    for (int k = 0; k < MAX_CELLS; k++) begin
      if ((k < int'(ncells)) &&
          !(inGrid(data[X_MSB0 + CELL_STRIDE*k -: 4]) &&
            inGrid(data[Y_MSB0 + CELL_STRIDE*k -: 4]))) begin
        ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vga_pos_update_ctrl.sv
// Accepts ship position updates over a req/ack handshake and commits them into
// the renderer position bus only during vertical blanking.
module vga_pos_update_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_SHIPS = 4,
  parameter int V_ACTIVE  = 480
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   areaAtiva,
  input  logic [9:0]             coluna,
  input  logic                   upd_req,
  input  logic [2:0]             upd_ship,
  input  logic [2:0]             upd_ncells,
  input  logic [63:0]            upd_data,
  output logic                   upd_ack,
  output logic                   upd_err,
  output logic [64*NUM_SHIPS-1:0] pos_bus,
  output logic                   frame_tick
);

  localparam int CELL_LSB0 = X_MSB0 - 3;
  localparam int CELL_BITS = Y_MSB0 - CELL_LSB0 + 1;

  updState_t   state;
  logic [2:0]  shadowShip;
  logic [2:0]  shadowNcells;
  logic [63:0] shadowData;
  logic [63:0] commitData;
  logic [63:0] slots [NUM_SHIPS];
  logic        rejected;
  logic        cellsOk;
  logic        shipOk;
  logic        inBlank;
  logic        inBlankQ;
  logic        unusedAreaAtiva;

  assign unusedAreaAtiva = areaAtiva;
  assign inBlank = (coluna >= 10'(V_ACTIVE));
  assign shipOk  = (32'(shadowShip) < NUM_SHIPS);

  vga_cell_check cellCheck (
    .data   (shadowData),
    .ncells (shadowNcells),
    .ok     (cellsOk)
  );

  always_comb begin
    commitData = '0;
    for (int k = 0; k < MAX_CELLS; k++) begin
      if (k < int'(shadowNcells)) begin
        commitData[CELL_LSB0 + CELL_STRIDE*k +: CELL_BITS] =
          shadowData[CELL_LSB0 + CELL_STRIDE*k +: CELL_BITS];
      end
    end
  end

  // The slot is written on entry to COMMIT, so pos_bus leads upd_ack by one
  // cycle; a reject waits one ACK cycle before raising upd_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadowShip   <= '0;
      shadowNcells <= '0;
      shadowData   <= '0;
      rejected     <= 1'b0;
      upd_ack      <= 1'b0;
      upd_err      <= 1'b0;
      for (int s = 0; s < NUM_SHIPS; s++) slots[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upd_req) begin
            shadowShip   <= upd_ship;
            shadowNcells <= upd_ncells;
            shadowData   <= upd_data;
            state        <= CHECK;
          end
        end
        CHECK: begin
          rejected <= !(shipOk && cellsOk);
          state    <= (shipOk && cellsOk) ? WAIT_BLANK : ACK;
        end
        WAIT_BLANK: begin
          if (inBlank) begin
            for (int s = 0; s < NUM_SHIPS; s++) begin
              if (32'(shadowShip) == s) slots[s] <= commitData;
            end
            state <= COMMIT;
          end
        end
        COMMIT: begin
          upd_ack <= 1'b1;
          upd_err <= 1'b0;
          state   <= ACK;
        end
        ACK: begin
          if (!upd_ack) begin
            upd_ack <= 1'b1;
            upd_err <= rejected;
          end else if (!upd_req) begin
            upd_ack <= 1'b0;
            upd_err <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starting with inBlankQ set suppresses a tick when reset releases in blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inBlankQ   <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      inBlankQ   <= inBlank;
      frame_tick <= inBlank & ~inBlankQ;
    end
  end

  always_comb begin
    pos_bus = '0;
    for (int s = 0; s < NUM_SHIPS; s++) pos_bus[64*s +: 64] = slots[s];
  end

endmodule

// File: tb/tb_vga_pos_update_ctrl.sv
// Randomized self-checking bench for vga_pos_update_ctrl against a
// transaction-level model of validation, masking and blank-synchronous commit.
module tb_vga_pos_update_ctrl;

  logic         clk;
  logic         rst_n;
  logic         areaAtiva;
  logic [9:0]   coluna;
  logic         upd_req;
  logic [2:0]   upd_ship;
  logic [2:0]   upd_ncells;
  logic [63:0]  upd_data;
  logic         upd_ack;
  logic         upd_err;
  logic [255:0] pos_bus;
  logic         frame_tick;

  int checks = 0;
  int passes = 0;
  logic [63:0] posModel [4];
  bit tickPrevBlank = 1'b1;
  bit expTick;

  vga_pos_update_ctrl #(.NUM_SHIPS(4), .V_ACTIVE(480)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .areaAtiva  (areaAtiva),
    .coluna     (coluna),
    .upd_req    (upd_req),
    .upd_ship   (upd_ship),
    .upd_ncells (upd_ncells),
    .upd_data   (upd_data),
    .upd_ack    (upd_ack),
    .upd_err    (upd_err),
    .pos_bus    (pos_bus),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Row counter over a 525-line frame, advanced on the falling edge.
  initial begin
    coluna    = 10'd500;
    areaAtiva = 1'b0;
    forever begin
      @(negedge clk);
      coluna    = (coluna == 10'd524) ? 10'd0 : coluna + 10'd1;
      areaAtiva = (coluna < 10'd480);
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  function automatic logic [255:0] flatPos();
    return {posModel[3], posModel[2], posModel[1], posModel[0]};
  endfunction

  function automatic logic [63:0] setCell(input logic [63:0] d, input int k, input int x, input int y);
    logic [63:0] r;
    r = d;
    r[6+8*k -: 4]  = 4'(x);
    r[10+8*k -: 4] = 4'(y);
    return r;
  endfunction

  function automatic bit modelValid(input int ship, input int nc, input logic [63:0] d);
    int x;
    int y;
    if (ship >= 4 || nc < 1 || nc > 4) return 1'b0;
    for (int k = 0; k < nc; k++) begin
      x = int'(d[6+8*k -: 4]);
      y = int'(d[10+8*k -: 4]);
      if (x < 1 || x > 8 || y < 1 || y > 8) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [63:0] modelSlot(input int nc, input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < nc && k < 4; k++) begin
      r = r | (64'(d[6+8*k -: 4]) << (3 + 8*k)) | (64'(d[10+8*k -: 4]) << (7 + 8*k));
    end
    return r;
  endfunction

  // Frame tick expected on the cycle after the row crosses into blank.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        expTick       = 1'b0;
        tickPrevBlank = 1'b1;
      end else begin
        expTick       = (coluna >= 10'd480) && !tickPrevBlank;
        tickPrevBlank = (coluna >= 10'd480);
      end
      #1 checkOutput("frameTick", 256'(frame_tick), 256'(expTick));
    end
  end

  task automatic waitColuna(input int target);
    int n;
    n = 0;
    while (coluna != 10'(target) && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  // Runs one complete handshake; called and returns just after a falling edge.
  task automatic applyStimulus(input int ship, input int nc, input logic [63:0] data,
                               input int holdCycles, input bit earlyDrop, input bit scramble);
    bit accept;
    int commitEdge;
    int ackEdge;
    logic [9:0] col;
    logic [63:0] newSlot;
    accept     = modelValid(ship, nc, data);
    newSlot    = modelSlot(nc, data);
    commitEdge = -1;
    ackEdge    = -1;
    upd_req    = 1'b1;
    upd_ship   = 3'(ship);
    upd_ncells = 3'(nc);
    upd_data   = data;
    @(posedge clk);
    @(negedge clk);
    #1;
    if (scramble) begin
      upd_ship   = 3'($urandom);
      upd_ncells = 3'($urandom);
      upd_data   = {$urandom, $urandom};
    end
    if (earlyDrop) upd_req = 1'b0;
    for (int i = 1; i < 1200 && ackEdge < 0; i++) begin
      @(posedge clk);
      col = coluna;
      #1;
      if (!accept) begin
        if (i == 2) ackEdge = i;
      end else begin
        if (commitEdge < 0 && i >= 2 && col >= 10'd480) begin
          commitEdge     = i;
          posModel[ship] = newSlot;
        end
        if (commitEdge >= 0 && i == commitEdge + 1) ackEdge = i;
      end
      checkOutput("posBus", pos_bus, flatPos());
      checkOutput("ack", 256'(upd_ack), 256'(ackEdge == i));
      if (ackEdge == i) checkOutput("err", 256'(upd_err), 256'(!accept));
    end
    if (!earlyDrop) begin
      for (int h = 0; h < holdCycles; h++) begin
        @(posedge clk);
        #1;
        checkOutput("ackHold", 256'(upd_ack), 256'(1));
        checkOutput("errHold", 256'(upd_err), 256'(!accept));
        checkOutput("posHold", pos_bus, flatPos());
      end
      @(negedge clk);
      #1;
      upd_req = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("ackFall", 256'(upd_ack), 256'(0));
    checkOutput("errFall", 256'(upd_err), 256'(0));
    @(negedge clk);
    #1;
  endtask

  task automatic randomTransaction();
    int ship;
    int nc;
    logic [63:0] d;
    ship = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) nc = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(5, 7));
    else nc = int'($urandom_range(1, 4));
    d = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      d = setCell(d, k,
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 8)),
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 8)));
    end
    repeat ($urandom_range(0, 150)) begin
      @(negedge clk);
      #1;
    end
    applyStimulus(ship, nc, d, int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
  endtask

  // Valid request abandoned by reset while waiting for blank.
  task automatic resetDuringWait();
    logic [63:0] d;
    d = setCell(64'h0, 0, 5, 5);
    waitColuna(100);
    upd_req    = 1'b1;
    upd_ship   = 3'd1;
    upd_ncells = 3'd1;
    upd_data   = d;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    upd_req = 1'b0;
    for (int s = 0; s < 4; s++) posModel[s] = '0;
    #1;
    checkOutput("rstPos", pos_bus, 256'(0));
    checkOutput("rstAck", 256'(upd_ack), 256'(0));
    checkOutput("rstErr", 256'(upd_err), 256'(0));
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      checkOutput("postRstAck", 256'(upd_ack), 256'(0));
      checkOutput("postRstPos", pos_bus, 256'(0));
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] base;
    logic [63:0] d;
    rst_n      = 1'b0;
    upd_req    = 1'b0;
    upd_ship   = '0;
    upd_ncells = '0;
    upd_data   = '0;
    for (int s = 0; s < 4; s++) posModel[s] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetPos", pos_bus, 256'(0));
    checkOutput("resetAck", 256'(upd_ack), 256'(0));
    checkOutput("resetErr", 256'(upd_err), 256'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    d = setCell(64'hFFFF_FFFF_FFFF_FFFF, 0, 3, 4);
    d = setCell(d, 1, 4, 4);
    waitColuna(100);
    applyStimulus(0, 2, d, 0, 1'b0, 1'b0);

    base = setCell(64'h0123_4567_89AB_CDEF, 0, 2, 2);
    base = setCell(base, 1, 3, 3);
    base = setCell(base, 2, 4, 4);
    base = setCell(base, 3, 5, 5);
    applyStimulus(1, 3, setCell(base, 1, 9, 3), 0, 1'b0, 1'b0);
    applyStimulus(1, 1, setCell(base, 0, 0, 2), 0, 1'b0, 1'b0);
    applyStimulus(1, 2, setCell(base, 1, 3, 9), 0, 1'b0, 1'b0);
    applyStimulus(1, 5, base, 0, 1'b0, 1'b0);
    applyStimulus(5, 4, base, 0, 1'b0, 1'b0);
    applyStimulus(2, 1, setCell(base, 2, 0, 15), 0, 1'b0, 1'b0);

    waitColuna(490);
    applyStimulus(3, 4, setCell(base, 3, 8, 8), 0, 1'b0, 1'b0);
    applyStimulus(0, 4, setCell(base, 0, 1, 1), 10, 1'b0, 1'b1);
    applyStimulus(0, 1, setCell(base, 0, 7, 6), 0, 1'b1, 1'b0);

    for (int t = 0; t < 20; t++) randomTransaction();
    resetDuringWait();
    waitColuna(490);
    applyStimulus(2, 2, base, 0, 1'b0, 1'b0);
    for (int t = 0; t < 20; t++) randomTransaction();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
